// File: rtl/fp_add_arbiter.sv
// fp_add_arbiter: round-robin sequencer sharing one combinational float adder
// among N requesters. Operands are registered into the adder, the sum is
// captured one cycle later and returned with the owner's ID over valid/ready.
module fp_add_arbiter #(
  parameter int N   = 4,
  parameter int IDW = $clog2(N)
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [N-1:0]    req_valid,
  input  logic [N*32-1:0] req_a,
  input  logic [N*32-1:0] req_b,
  output logic [N-1:0]    req_ready,
  output logic [31:0]     add_a,
  output logic [31:0]     add_b,
  input  logic [31:0]     add_y,
  output logic            rsp_valid,
  output logic [IDW-1:0]  rsp_id,
  output logic [31:0]     rsp_y,
  input  logic            rsp_ready,
  output logic            busy
);

  localparam int unsigned NU = N;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [IDW-1:0] last_grant_q, last_grant_d;
  logic [31:0]    add_a_q, add_a_d;
  logic [31:0]    add_b_q, add_b_d;
  logic [31:0]    rsp_y_q, rsp_y_d;
  logic [IDW-1:0] rsp_id_q, rsp_id_d;
  logic           rsp_valid_q, rsp_valid_d;

  logic           gnt_found;
  logic [IDW-1:0] gnt_idx;

  // Round-robin search starting one past the last grant, wrapping modulo N.
  always_comb begin
    int unsigned cand;
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = 0;
    for (int unsigned k = 1; k <= NU; k++) begin
      cand = (32'(last_grant_q) + k) % NU;
      if (!gnt_found && req_valid[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = IDW'(cand);
      end
    end
  end

  // Accept strobe: only the winner, only in IDLE, never while reset is held.
  always_comb begin
    req_ready = '0;
    if (reset_n && (state_q == IDLE) && gnt_found) begin
      req_ready[gnt_idx] = 1'b1;
    end
  end

  // Next-state and datapath capture for the IDLE -> CALC -> RESP sequence.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    add_a_d      = add_a_q;
    add_b_d      = add_b_q;
    rsp_y_d      = rsp_y_q;
    rsp_id_d     = rsp_id_q;
    rsp_valid_d  = rsp_valid_q;
    unique case (state_q)
      IDLE: begin
        if (gnt_found) begin
          add_a_d      = req_a[32*gnt_idx +: 32];
          add_b_d      = req_b[32*gnt_idx +: 32];
          rsp_id_d     = gnt_idx;
          last_grant_d = gnt_idx;
          state_d      = CALC;
        end
      end
      CALC: begin
        rsp_y_d     = add_y;
        rsp_valid_d = 1'b1;
        state_d     = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: begin
        rsp_valid_d = 1'b0;
        state_d     = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      last_grant_q <= IDW'(N - 1);
      add_a_q      <= '0;
      add_b_q      <= '0;
      rsp_y_q      <= '0;
      rsp_id_q     <= '0;
      rsp_valid_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      add_a_q      <= add_a_d;
      add_b_q      <= add_b_d;
      rsp_y_q      <= rsp_y_d;
      rsp_id_q     <= rsp_id_d;
      rsp_valid_q  <= rsp_valid_d;
    end
  end

  assign add_a     = add_a_q;
  assign add_b     = add_b_q;
  assign rsp_y     = rsp_y_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_valid = rsp_valid_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_fp_add_arbiter.sv
// Directed bench for fp_add_arbiter with a small lookup-table float adder.
module tb_fp_add_arbiter;

  localparam int N   = 4;
  localparam int IDW = 2;

  logic            clk = 1'b0;
  logic            reset_n;
  logic [N-1:0]    req_valid;
  logic [N*32-1:0] req_a;
  logic [N*32-1:0] req_b;
  logic [N-1:0]    req_ready;
  logic [31:0]     add_a, add_b, add_y;
  logic            rsp_valid;
  logic [IDW-1:0]  rsp_id;
  logic [31:0]     rsp_y;
  logic            rsp_ready;
  logic            busy;

  int unsigned pass_cnt = 0;
  int unsigned chk_cnt  = 0;

  // Expected sums per requester: 1+2=3, 5+(-3)=2, 2+2=4, 0.5+0.5=1
  logic [31:0] exp_sum [N];

  always #5 clk = ~clk;

  fp_add_arbiter #(.N(N), .IDW(IDW)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req_valid (req_valid),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_ready (req_ready),
    .add_a     (add_a),
    .add_b     (add_b),
    .add_y     (add_y),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .rsp_y     (rsp_y),
    .rsp_ready (rsp_ready),
    .busy      (busy)
  );

  // Stand-in adder: only the operand pairs used by the bench are known.
  always_comb begin
    case ({add_a, add_b})
      {32'h3F800000, 32'h40000000}: add_y = 32'h40400000;
      {32'h40A00000, 32'hC0400000}: add_y = 32'h40000000;
      {32'h40000000, 32'h40000000}: add_y = 32'h40800000;
      {32'h3F000000, 32'h3F000000}: add_y = 32'h3F800000;
      default:                      add_y = 32'hFFFFFFFF;
    endcase
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset_n   = 1'b0;
    req_valid = '0;
    rsp_ready = 1'b1;
    tick();
    tick();
    reset_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    apply_reset();
    chk_cnt++;
    if ({rsp_valid, busy, rsp_y, rsp_id, add_a, add_b} !== '0)
      $display("FAIL reset_state: got v=%0b busy=%0b y=%h id=%0d a=%h b=%h, want all zero",
               rsp_valid, busy, rsp_y, rsp_id, add_a, add_b);
    else pass_cnt++;
    reset_n   = 1'b0;
    req_valid = 4'b1111;
    #1;
    chk_cnt++;
    if (req_ready !== 4'b0000)
      $display("FAIL reset_ready: got %b want 0000", req_ready);
    else pass_cnt++;
    apply_reset();
  endtask

  task automatic test_single();
    apply_reset();
    req_valid = 4'b0001;
    #1;
    chk_cnt++;
    if (req_ready !== 4'b0001 || busy !== 1'b0)
      $display("FAIL single_grant: ready=%b busy=%0b want 0001 0", req_ready, busy);
    else pass_cnt++;
    tick();
    req_valid = '0;
    #1;
    chk_cnt++;
    if (busy !== 1'b1 || rsp_valid !== 1'b0 || req_ready !== 4'b0000 ||
        add_a !== 32'h3F800000 || add_b !== 32'h40000000)
      $display("FAIL single_calc: busy=%0b v=%0b ready=%b a=%h b=%h", busy, rsp_valid,
               req_ready, add_a, add_b);
    else pass_cnt++;
    tick();
    chk_cnt++;
    if (rsp_valid !== 1'b1 || rsp_y !== 32'h40400000 || rsp_id !== 2'd0 || busy !== 1'b1)
      $display("FAIL single_resp: v=%0b y=%h id=%0d busy=%0b want 1 40400000 0 1",
               rsp_valid, rsp_y, rsp_id, busy);
    else pass_cnt++;
    tick();
    chk_cnt++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0 || add_a !== 32'h3F800000)
      $display("FAIL single_done: v=%0b busy=%0b a=%h want 0 0 3f800000", rsp_valid, busy, add_a);
    else pass_cnt++;
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_g [5];
    exp_g = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    apply_reset();
    req_valid = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk_cnt++;
      if (req_ready !== (4'b0001 << exp_g[i]))
        $display("FAIL rr_grant%0d: ready=%b want %b", i, req_ready, 4'b0001 << exp_g[i]);
      else pass_cnt++;
      tick();
      tick();
      chk_cnt++;
      if (rsp_valid !== 1'b1 || rsp_id !== exp_g[i] || rsp_y !== exp_sum[exp_g[i]] ||
          req_ready !== 4'b0000)
        $display("FAIL rr_resp%0d: v=%0b id=%0d y=%h ready=%b want 1 %0d %h 0000",
                 i, rsp_valid, rsp_id, rsp_y, req_ready, exp_g[i], exp_sum[exp_g[i]]);
      else pass_cnt++;
      tick();
    end
    req_valid = '0;
  endtask

  task automatic test_back_to_back_backpressure();
    apply_reset();
    req_valid = 4'b0100;
    rsp_ready = 1'b0;
    tick();
    req_valid = 4'b0101;
    tick();
    for (int i = 0; i < 5; i++) begin
      chk_cnt++;
      if (rsp_valid !== 1'b1 || rsp_id !== 2'd2 || rsp_y !== 32'h40800000 ||
          req_ready !== 4'b0000 || busy !== 1'b1)
        $display("FAIL bp_hold%0d: v=%0b id=%0d y=%h ready=%b busy=%0b", i, rsp_valid,
                 rsp_id, rsp_y, req_ready, busy);
      else pass_cnt++;
      tick();
    end
    rsp_ready = 1'b1;
    #1;
    chk_cnt++;
    if (req_ready !== 4'b0000)
      $display("FAIL bp_handshake_nogrant: ready=%b want 0000", req_ready);
    else pass_cnt++;
    tick();
    chk_cnt++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0 || req_ready !== 4'b0001)
      $display("FAIL bp_release: v=%0b busy=%0b ready=%b want 0 0 0001", rsp_valid, busy, req_ready);
    else pass_cnt++;
    req_valid = '0;
    tick();
    tick();
    tick();
  endtask

  task automatic test_wrap();
    logic [1:0] exp_g [3];
    exp_g = '{2'd0, 2'd2, 2'd0};
    apply_reset();
    req_valid = 4'b0101;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk_cnt++;
      if (req_ready !== (4'b0001 << exp_g[i]))
        $display("FAIL wrap_grant%0d: ready=%b want %b", i, req_ready, 4'b0001 << exp_g[i]);
      else pass_cnt++;
      tick();
      tick();
      tick();
    end
    req_valid = '0;
  endtask

  task automatic test_reset_mid_op();
    apply_reset();
    req_valid = 4'b0100;
    tick();
    reset_n   = 1'b0;
    req_valid = 4'b0101;
    tick();
    chk_cnt++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0)
      $display("FAIL midreset_abort: v=%0b busy=%0b want 0 0", rsp_valid, busy);
    else pass_cnt++;
    reset_n = 1'b1;
    #1;
    chk_cnt++;
    if (req_ready !== 4'b0001)
      $display("FAIL midreset_priority: ready=%b want 0001", req_ready);
    else pass_cnt++;
    tick();
    req_valid = '0;
    tick();
    chk_cnt++;
    if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_y !== 32'h40400000)
      $display("FAIL midreset_resp: v=%0b id=%0d y=%h want 1 0 40400000", rsp_valid, rsp_id, rsp_y);
    else pass_cnt++;
    tick();
  endtask

  task automatic test_signed();
    apply_reset();
    req_valid = 4'b0010;
    tick();
    req_valid = '0;
    tick();
    chk_cnt++;
    if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_y !== 32'h40000000)
      $display("FAIL signed_sum: v=%0b id=%0d y=%h want 1 1 40000000", rsp_valid, rsp_id, rsp_y);
    else pass_cnt++;
    tick();
  endtask

  initial begin
    reset_n   = 1'b0;
    req_valid = '0;
    rsp_ready = 1'b1;
    req_a = {32'h3F000000, 32'h40000000, 32'h40A00000, 32'h3F800000};
    req_b = {32'h3F000000, 32'h40000000, 32'hC0400000, 32'h40000000};
    exp_sum = '{32'h40400000, 32'h40000000, 32'h40800000, 32'h3F800000};
    test_reset();
    test_single();
    test_round_robin();
    test_back_to_back_backpressure();
    test_wrap();
    test_reset_mid_op();
    test_signed();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
